stack_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `stack` instance (8 entries × 8 bits) between `N_REQ` requesters. It accepts one push or pop request at a time and drives the stack's `push`/`pop`/`data_in` strobes. It keeps its own occupancy count, so illegal operations (push when full, pop when empty) are rejected with an error response and never reach the stack. It returns pop data and completion to the granted requester. It sits between requester blocks and the stack datapath; the stack's `reset` is driven by `~reset_n`.

---
 rtl/stack_pkg.sv | 29 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/stack_arbiter.sv | 143 ++++++++++++++
 tb/tb_stack_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack arbiter and its stack datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   state_t      - sequencer states IDLE / ISSUE / RESP
//   DEF_DEPTH    - default stack capacity
//   DEF_WIDTH    - default stack data width
//   count_width  - width needed to hold an occupancy of 0..depth
//   CNT_W        - occupancy width for the default depth
package stack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    // The count has to reach DEPTH itself, hence depth+1 values.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W = count_width(DEF_DEPTH);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the previous winner; search starts just above it
//   grant      - one-hot winner (all zero when no request)
//   any_req    - at least one request is present
module rr_picker #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic          any_req
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the N positions starting at last_grant+1 and wrapping; the first
    // active request wins. last_grant itself is visited last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last_grant) + off) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer sharing one stack between N_REQ requesters.
// Latency: req_ready at T, stack strobe at T+1, rsp_valid at T+2 (one txn per 3 cycles).
// Backpressure: requesters hold req_valid until req_ready; responses are unconditioned pulses.
//
// Ports:
//   clk, reset_n        - clock and asynchronous active-low reset
//   req_valid/pop/data  - per-requester request, op (1=pop) and push data slice
//   req_ready           - one-hot grant pulse
//   rsp_valid/data/err  - one-hot completion pulse, popped value, rejection flag
//   stk_push/pop/data_in, stk_data_out - strobes to / registered data from the stack
//   count, full, empty  - occupancy tracked here; the stack's own flags are unused
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  WIDTH = DEF_WIDTH,
    localparam int IW    = $clog2(N_REQ),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_pop,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [WIDTH-1:0]       stk_data_in,
    input  logic [WIDTH-1:0]       stk_data_out,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  pick;
    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    // The latched winner doubles as the round-robin pointer: both are the
    // index of the most recent grant, so one register serves both roles.
    logic [IW-1:0]     win_idx_q;
    logic              op_pop_q;
    logic [WIDTH-1:0]  op_data_q;
    logic              err_q;
    logic [CW-1:0]     count_q;
    logic              can_push, can_pop, op_ok;

    rr_picker #(.N(N_REQ)) u_picker (
        .req        (req_valid),
        .last_grant (win_idx_q),
        .grant      (pick),
        .any_req    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    assign can_push = (count_q != DEPTH_C);
    assign can_pop  = (count_q != '0);
    assign op_ok    = op_pop_q ? can_pop : can_push;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; the IDLE grant is the one place
    // req_valid reaches an output, through the picker.
    always_comb begin
        req_ready   = '0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        rsp_valid   = '0;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        case (state_q)
            ST_IDLE: req_ready = pick;
            ST_ISSUE: begin
                // Rejected ops never strobe the stack.
                stk_push = !op_pop_q && can_push;
                stk_pop  = op_pop_q && can_pop;
                if (!op_pop_q && can_push) stk_data_in = op_data_q;
            end
            ST_RESP: begin
                rsp_valid[win_idx_q] = 1'b1;
                rsp_err              = err_q;
                // The stack registered data_out on the edge ending ISSUE.
                if (op_pop_q && !err_q) rsp_data = stk_data_out;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_idx_q <= IW'(N_REQ - 1);  // requester 0 searched first
            op_pop_q  <= 1'b0;
            op_data_q <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && pick_any) begin
                win_idx_q <= pick_idx;
                op_pop_q  <= req_pop[pick_idx];
                op_data_q <= req_data[pick_idx*WIDTH +: WIDTH];
            end
            if (state_q == ST_ISSUE) begin
                err_q <= !op_ok;
                if (op_ok) begin
                    count_q <= op_pop_q ? (count_q - CW'(1)) : (count_q + CW'(1));
                end
            end
        end
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid, req_pop, req_ready, rsp_valid;
    logic [31:0] req_data;
    logic [7:0]  rsp_data, stk_data_in, stk_data_out;
    logic        rsp_err, stk_push, stk_pop, full, empty;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: LIFO contents and the round-robin pointer.
    logic [7:0] mq[$];
    int         last_g;

    always #5 clk = ~clk;

    stack_arbiter #(.N_REQ(4), .DEPTH(8), .WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_pop      (req_pop),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Behavioural 8x8 stack attached to the arbiter, reset by ~reset_n.
    logic [7:0] smem [8];
    int         sp;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push) begin
            if (sp < 8) begin
                smem[sp] <= stk_data_in;
                sp       <= sp + 1;
            end
        end else if (stk_pop) begin
            if (sp > 0) begin
                stk_data_out <= smem[sp-1];
                sp           <= sp - 1;
            end
        end
    end

    typedef struct packed {
        logic       timeout;
        logic [3:0] ready;
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [3:0] rvld_early;
        logic [3:0] rvld;
        logic       err;
        logic [7:0] rdata;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
    } obs_t;

    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    // Present a request set at posedge+1 and capture the grant cycle (T),
    // the strobe cycle (T+1) and the response cycle (T+2). Returns at posedge+1.
    task automatic txn(input logic [3:0] mask, input logic [3:0] pops,
                       input logic [31:0] datas, output obs_t o);
        int w;
        o         = '0;
        o.timeout = 1'b1;
        req_valid = mask;
        req_pop   = pops;
        req_data  = datas;
        w = 0;
        while (w < 16) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                o.timeout = 1'b0;
                o.ready   = req_ready;
                w         = 16;
            end else begin
                @(posedge clk); #1;
                w++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        o.push       = stk_push;
        o.pop        = stk_pop;
        o.din        = stk_data_in;
        o.rvld_early = rsp_valid;
        @(negedge clk);
        o.rvld  = rsp_valid;
        o.err   = rsp_err;
        o.rdata = rsp_data;
        o.cnt   = count;
        o.full  = full;
        o.empty = empty;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        last_g = 3;
    endtask

    task automatic test_reset();
        logic [38:0] got;
        reset_n = 1'b0;
        req_valid = '0;
        #3;
        got = {req_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_data_in, count, full, empty};
        n_checks++;
        if (got !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            $display("FAIL reset_outputs: got %h expected %h", got,
                     {4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1});
        else n_pass++;
        do_reset();
        repeat (2) @(negedge clk);
        got = {req_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_data_in, count, full, empty};
        n_checks++;
        if (got !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            $display("FAIL idle_after_reset: got %h expected %h", got,
                     {4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_push_basic();
        obs_t o;
        do_reset();
        txn(4'b0100, 4'b0000, 32'h00A5_0000, o);
        mq.push_back(8'hA5);
        last_g = 2;
        n_checks++;
        if ({o.ready, o.push, o.pop, o.din} !== {4'b0100, 1'b1, 1'b0, 8'hA5})
            $display("FAIL push_grant_strobe: got ready=%b push=%b pop=%b din=%h expected 0100/1/0/a5",
                     o.ready, o.push, o.pop, o.din);
        else n_pass++;
        n_checks++;
        if ({o.rvld_early, o.rvld, o.err, o.cnt, o.empty} !== {4'b0000, 4'b0100, 1'b0, 4'd1, 1'b0})
            $display("FAIL push_response: got early=%b rvld=%b err=%b count=%0d empty=%b expected 0000/0100/0/1/0",
                     o.rvld_early, o.rvld, o.err, o.cnt, o.empty);
        else n_pass++;
    endtask

    task automatic test_push_pop();
        obs_t o;
        do_reset();
        txn(4'b0001, 4'b0000, 32'h0000_0011, o);
        n_checks++;
        if ({o.ready, o.rvld, o.err, o.cnt} !== {4'b0001, 4'b0001, 1'b0, 4'd1})
            $display("FAIL push11: got ready=%b rvld=%b err=%b count=%0d expected 0001/0001/0/1",
                     o.ready, o.rvld, o.err, o.cnt);
        else n_pass++;
        txn(4'b0010, 4'b0010, 32'h0000_EE00, o);
        n_checks++;
        if ({o.ready, o.push, o.pop} !== {4'b0010, 1'b0, 1'b1})
            $display("FAIL pop_strobe: got ready=%b push=%b pop=%b expected 0010/0/1",
                     o.ready, o.push, o.pop);
        else n_pass++;
        n_checks++;
        if ({o.rvld, o.err, o.rdata, o.cnt, o.empty} !== {4'b0010, 1'b0, 8'h11, 4'd0, 1'b1})
            $display("FAIL pop_response: got rvld=%b err=%b data=%h count=%0d empty=%b expected 0010/0/11/0/1",
                     o.rvld, o.err, o.rdata, o.cnt, o.empty);
        else n_pass++;
        last_g = 1;
    endtask

    task automatic test_round_robin();
        logic [3:0] g_vec [5];
        int         g_cyc [5];
        int         n, cyc;
        do_reset();
        req_pop   = '0;
        req_data  = 32'h3332_3130;
        req_valid = 4'hF;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 40) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                g_vec[n] = req_ready;
                g_cyc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (n !== 5) $display("FAIL rr_grant_count: got %0d grants expected 5", n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (g_vec[i] !== 4'(1 << (i % 4)))
                $display("FAIL rr_order[%0d]: got %b expected %b", i, g_vec[i], 4'(1 << (i % 4)));
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (g_cyc[i] - g_cyc[i-1] !== 3)
                    $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, g_cyc[i] - g_cyc[i-1]);
                else n_pass++;
            end
            mq.push_back(8'h30 + 8'(i % 4));
        end
        last_g = 0;
        n_checks++;
        if (count !== 4'(mq.size()))
            $display("FAIL rr_count: got %0d expected %0d", count, mq.size());
        else n_pass++;
    endtask

    task automatic test_full();
        obs_t       o;
        logic [7:0] d;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            txn(4'(1 << (i % 4)), 4'b0000, {4{d}}, o);
            mq.push_back(d);
        end
        last_g = 3;
        n_checks++;
        if ({count, full, empty} !== {4'd8, 1'b1, 1'b0})
            $display("FAIL fill8: got count=%0d full=%b empty=%b expected 8/1/0", count, full, empty);
        else n_pass++;
        txn(4'b0001, 4'b0000, 32'h0000_0077, o);
        last_g = 0;
        n_checks++;
        if ({o.ready, o.push, o.pop} !== {4'b0001, 1'b0, 1'b0})
            $display("FAIL full_push_strobe: got ready=%b push=%b pop=%b expected 0001/0/0",
                     o.ready, o.push, o.pop);
        else n_pass++;
        n_checks++;
        if ({o.rvld, o.err, o.rdata, o.cnt, o.full} !== {4'b0001, 1'b1, 8'h00, 4'd8, 1'b1})
            $display("FAIL full_push_resp: got rvld=%b err=%b data=%h count=%0d full=%b expected 0001/1/00/8/1",
                     o.rvld, o.err, o.rdata, o.cnt, o.full);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            e = mq.pop_back();
            txn(4'b0010, 4'b0010, 32'h0, o);
            n_checks++;
            if ({o.err, o.rdata, o.cnt} !== {1'b0, e, 4'(mq.size())})
                $display("FAIL drain[%0d]: got err=%b data=%h count=%0d expected 0/%h/%0d",
                         i, o.err, o.rdata, o.cnt, e, mq.size());
            else n_pass++;
        end
        last_g = 1;
    endtask

    task automatic test_empty_pop();
        obs_t o;
        do_reset();
        txn(4'b1000, 4'b1000, 32'hFF00_0000, o);
        last_g = 3;
        n_checks++;
        if ({o.ready, o.push, o.pop} !== {4'b1000, 1'b0, 1'b0})
            $display("FAIL empty_pop_strobe: got ready=%b push=%b pop=%b expected 1000/0/0",
                     o.ready, o.push, o.pop);
        else n_pass++;
        n_checks++;
        if ({o.rvld, o.err, o.rdata, o.cnt, o.empty} !== {4'b1000, 1'b1, 8'h00, 4'd0, 1'b1})
            $display("FAIL empty_pop_resp: got rvld=%b err=%b data=%h count=%0d empty=%b expected 1000/1/00/0/1",
                     o.rvld, o.err, o.rdata, o.cnt, o.empty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   hits;
        do_reset();
        req_pop   = '0;
        req_data  = 32'h0000_5C00;
        req_valid = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL midrst_grant: got %b expected 0010", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        n_checks++;
        if ({stk_push, count, empty} !== {1'b0, 4'd0, 1'b1})
            $display("FAIL midrst_state: got push=%b count=%0d empty=%b expected 0/0/1", stk_push, count, empty);
        else n_pass++;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) hits++;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        mq.delete();
        last_g = 3;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) hits++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (hits !== 0) $display("FAIL midrst_no_rsp: got %0d response cycles expected 0", hits);
        else n_pass++;
        txn(4'b0101, 4'b0000, 32'h0042_0024, o);
        mq.push_back(8'h24);
        last_g = 0;
        n_checks++;
        if ({o.ready, o.cnt} !== {4'b0001, 4'd1})
            $display("FAIL midrst_next_grant: got ready=%b count=%0d expected 0001/1", o.ready, o.cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o;
        logic [3:0]  mask, pops;
        logic [31:0] datas;
        logic [7:0]  d, e_rd;
        int          w;
        logic        e_pop, e_err;
        for (int it = 0; it < 60; it++) begin
            mask  = 4'($urandom_range(1, 15));
            pops  = 4'($urandom);
            datas = $urandom;
            w     = rr_pick(mask, last_g);
            e_pop = pops[w];
            d     = datas[w*8 +: 8];
            e_rd  = 8'h00;
            e_err = 1'b0;
            if (e_pop) begin
                if (mq.size() == 0) e_err = 1'b1;
                else e_rd = mq.pop_back();
            end else begin
                if (mq.size() == 8) e_err = 1'b1;
                else mq.push_back(d);
            end
            last_g = w;
            txn(mask, pops, datas, o);
            n_checks++;
            if ({o.ready, o.push, o.pop, o.rvld_early} !==
                {4'(1 << w), !e_pop && !e_err, e_pop && !e_err, 4'b0000})
                $display("FAIL rnd_grant[%0d]: got ready=%b push=%b pop=%b early=%b expected %b/%b/%b/0000",
                         it, o.ready, o.push, o.pop, o.rvld_early, 4'(1 << w), !e_pop && !e_err, e_pop && !e_err);
            else n_pass++;
            n_checks++;
            if ({o.rvld, o.err, o.rdata, o.cnt, o.full, o.empty} !==
                {4'(1 << w), e_err, e_rd, 4'(mq.size()), mq.size() == 8, mq.size() == 0})
                $display("FAIL rnd_resp[%0d]: got rvld=%b err=%b data=%h count=%0d expected %b/%b/%h/%0d",
                         it, o.rvld, o.err, o.rdata, o.cnt, 4'(1 << w), e_err, e_rd, mq.size());
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_pop   = '0;
        req_data  = '0;
        last_g    = 3;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_push_basic();
        test_push_pop();
        test_round_robin();
        test_full();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
